aleph_miner_axi_read_master: RTL and testbench
==============================================

# aleph_miner_axi_read_master

AXI4 read master that fetches a contiguous byte range from memory and presents it as a valid/ready beat stream. It is the read-side counterpart of the kernel's AXI write master: it loads header/target buffers from global memory into the miner datapath. It shares the write master's alignment rules, maximum burst size and `ctrl_start`/`ctrl_done` control style.

## Interface
- `C_M_AXI_ADDR_WIDTH`, default 64: AXI address width.
- `C_M_AXI_DATA_WIDTH`, default 32: AXI data width; one of 32/64/128/256/512/1024.
- `C_XFER_SIZE_WIDTH`, default `C_M_AXI_ADDR_WIDTH`: width of the size input; range 16..`C_M_AXI_ADDR_WIDTH`.
- `C_MAX_OUTSTANDING`, default 4: maximum number of issued AR bursts whose `rlast` has not yet been accepted; range 1..16.
- `aclk` in 1: the single clock.
- `areset` in 1: asynchronous, active-low reset.
- `ctrl_start` in 1: one-cycle start pulse; ignored unless the block is IDLE.
- `ctrl_done` out 1: one-cycle pulse when the transfer is complete.
- `ctrl_addr_offset` in ADDR: start address, sampled on an accepted `ctrl_start`.
- `ctrl_xfer_size_in_bytes` in XFER: byte count, sampled on an accepted `ctrl_start`.
- `m_axi_arvalid` out 1; `m_axi_arready` in 1; `m_axi_araddr` out ADDR; `m_axi_arlen` out 8: AXI read address channel.
- `m_axi_rvalid` in 1; `m_axi_rready` out 1; `m_axi_rdata` in DATA; `m_axi_rlast` in 1: AXI read data channel.
- `Vld_O` out 1; `Rdy_I` in 1; `Data_O` out DATA: output beat stream.
- `Last_O` out 1: marks the final beat of the whole transfer.

## Operation
Derived constants:
- DWB = DATA/8.
- BL = min(4096/DWB, 256) beats per burst.
- BB = DWB·BL bytes per burst.

States:
- IDLE: waits for `ctrl_start`. On `ctrl_start`, register:
  - base = `ctrl_addr_offset` & ~(BB-1), i.e. aligned down to BB;
  - beats = ceil(size/DWB).
  - Then go to LOAD.
- LOAD (1 cycle): compute from beats:
  - bursts = ceil(beats/BL);
  - final_len = ((beats-1) mod BL), in arlen encoding;
  - if beats==0, go to DONE; otherwise go to RUN.
- RUN: two independent channels.
  - AR channel: `m_axi_arvalid` is asserted while bursts_left>0 and outstanding<`C_MAX_OUTSTANDING`.
    - `araddr` and `arlen` are held stable until `arready`.
    - `arlen` = BL-1, except final_len on the last burst.
    - On an AR transfer: `araddr` += BB, bursts_left -= 1.
  - R channel: passes straight through, with no internal buffering.
    - `Vld_O` = `m_axi_rvalid` & RUN.
    - `m_axi_rready` = `Rdy_I` & RUN.
    - `Data_O` = `m_axi_rdata`.
  - Outstanding counter:
    - +1 on an AR transfer;
    - -1 on an accepted beat with `m_axi_rlast`;
    - both in the same cycle leaves it unchanged.
  - Beat counter counts accepted beats. `Last_O` = (beat counter == beats-1) & `Vld_O`.
  - Once the final beat is accepted, go to DONE.
- DONE (1 cycle): assert `ctrl_done`, then return to IDLE.

Widths and wrap rules:
- The beat counter and beats are XFER-LOG2(DWB)+1 bits wide.
- `araddr` wraps modulo 2^ADDR with no error.
- Responses (`rresp`) are not inspected.
- A beat with `m_axi_rlast` high that does not match the expected burst length is not checked. Completion is decided by the beat count only.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset asserted mid-transfer aborts the transfer immediately and leaves the AXI bus in an indeterminate state; a host-level reset of the interconnect is required.
- `ctrl_start` in cycle 0 puts the block in LOAD in cycle 1. The first `m_axi_arvalid` rises at cycle 2 at the earliest.
- Once `arvalid` is high, `arvalid`, `araddr` and `arlen` must not change until `arready` is high.
- `arvalid` never depends combinationally on `arready`.
- R path is combinational: zero-cycle latency from `rvalid` to `Vld_O` and from `Rdy_I` to `rready`.
- `ctrl_done` pulses exactly 2 cycles after the final beat transfer (final beat → DONE → pulse).
- A zero-length transfer pulses `ctrl_done` 3 cycles after `ctrl_start`, with no AR transfers.
- `ctrl_start` while not IDLE is ignored and has no effect on registered parameters.

## Test plan
- DATA=32, addr 0x1000, size 16: one AR with araddr 0x1000, arlen 3 → 4 beats; `Last_O` only on the 4th; `ctrl_done` 2 cycles after it.
- size 2500, addr 0x1234: 625 beats → ARs at 0x1000/0x1400/0x1800 with arlen 255/255/112; `Last_O` on beat 625.
- size 6: arlen 1, 2 beats. size 0: no AR, `ctrl_done` at cycle 3.
- `arready` tied 1, `rvalid` withheld, size 8192: exactly `C_MAX_OUTSTANDING`=4 ARs issued, then `arvalid` stays low; releasing one full burst allows exactly one more AR.
- `Rdy_I` toggled randomly: `rready` mirrors it; no beat is lost or duplicated; `arvalid`/`araddr` stable under `arready`=0 for 5 cycles.
- `areset` low in the middle of burst 2 → all outputs 0 asynchronously. After release, a new `ctrl_start` transfers correctly. A `ctrl_start` issued during RUN is ignored (araddr sequence unchanged).

Source files
------------

// File: rtl/aleph_miner_axi_read_master.sv
// AXI4 read master: fetches a contiguous, burst-aligned byte range and streams
// the returned beats through an unbuffered valid/ready port.
module aleph_miner_axi_read_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = C_M_AXI_ADDR_WIDTH,
  parameter int C_MAX_OUTSTANDING  = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ctrl_start,
  output logic                          ctrl_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,
  output logic                          Vld_O,
  input  logic                          Rdy_I,
  output logic [C_M_AXI_DATA_WIDTH-1:0] Data_O,
  output logic                          Last_O
);
  localparam int DWB     = C_M_AXI_DATA_WIDTH / 8;
  localparam int LOG_DWB = $clog2(DWB);
  localparam int BL      = (4096 / DWB < 256) ? 4096 / DWB : 256;
  localparam int LOG_BL  = $clog2(BL);
  localparam int BB      = DWB * BL;
  localparam int BW      = C_XFER_SIZE_WIDTH - LOG_DWB + 1;
  localparam int OW      = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int AW      = C_M_AXI_ADDR_WIDTH;
  localparam int XW      = C_XFER_SIZE_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [BW-1:0] beats, beat_cnt, bursts_left;
  logic [7:0]    final_len;
  logic [OW-1:0] outstanding;

  logic          run, beat_acc, last_beat, ar_xfer, r_done;
  logic [BW-1:0] beats_calc, bursts_calc, bursts_nxt;
  logic [7:0]    final_len_calc;
  logic [OW-1:0] out_nxt;

  // R channel is a pure pass-through, gated only by the RUN state.
  assign run          = (state == S_RUN);
  assign Vld_O        = m_axi_rvalid & run;
  assign m_axi_rready = Rdy_I & run;
  assign Data_O       = m_axi_rdata;
  assign beat_acc     = Vld_O & Rdy_I;
  assign last_beat    = (beat_cnt == beats - BW'(1));
  assign Last_O       = last_beat & Vld_O;
  assign ar_xfer      = m_axi_arvalid & m_axi_arready;
  assign r_done       = beat_acc & m_axi_rlast;

  // Round-up divisions use one extra bit so size/beat counts near the top never wrap.
  assign beats_calc     = BW'(({1'b0, ctrl_xfer_size_in_bytes} + (XW+1)'(DWB - 1)) >> LOG_DWB);
  assign bursts_calc    = BW'(({1'b0, beats} + (BW+1)'(BL - 1)) >> LOG_BL);
  assign final_len_calc = 8'((beats - BW'(1)) & BW'(BL - 1));
  assign bursts_nxt     = bursts_left - BW'(ar_xfer);
  assign out_nxt        = outstanding + OW'(ar_xfer) - OW'(r_done);

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state         <= S_IDLE;
      beats         <= '0;
      beat_cnt      <= '0;
      bursts_left   <= '0;
      final_len     <= '0;
      outstanding   <= '0;
      ctrl_done     <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
    end else begin
      ctrl_done <= 1'b0;
      case (state)
        S_IDLE: if (ctrl_start) begin
          m_axi_araddr <= ctrl_addr_offset & ~AW'(BB - 1);
          beats        <= beats_calc;
          state        <= S_LOAD;
        end
        S_LOAD: begin
          bursts_left   <= bursts_calc;
          final_len     <= final_len_calc;
          m_axi_arlen   <= (bursts_calc == BW'(1)) ? final_len_calc : 8'(BL - 1);
          beat_cnt      <= '0;
          outstanding   <= '0;
          m_axi_arvalid <= (beats != '0);
          state         <= (beats == '0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          // arvalid is a registered view of next-cycle credit; it cannot drop
          // while stalled because outstanding only shrinks in that case.
          if (ar_xfer) begin
            m_axi_araddr <= m_axi_araddr + AW'(BB);
            m_axi_arlen  <= (bursts_nxt == BW'(1)) ? final_len : 8'(BL - 1);
          end
          bursts_left   <= bursts_nxt;
          outstanding   <= out_nxt;
          m_axi_arvalid <= (bursts_nxt != '0) && (out_nxt < OW'(C_MAX_OUTSTANDING));
          if (beat_acc) begin
            beat_cnt <= beat_cnt + BW'(1);
            if (last_beat) begin
              m_axi_arvalid <= 1'b0;
              state         <= S_DONE;
            end
          end
        end
        S_DONE: begin
          ctrl_done <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aleph_miner_axi_read_master.sv
// Directed bench: transfer-timeline model + AXI slave model, checked every cycle.
module tb_aleph_miner_axi_read_master;
  logic        aclk = 1'b0, areset;
  logic        ctrl_start, ctrl_done;
  logic [63:0] ctrl_addr_offset, ctrl_xfer_size_in_bytes;
  logic        arvalid, arready, rvalid, rready, rlast, Vld_O, Rdy_I, Last_O;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [31:0] rdata, Data_O;

  aleph_miner_axi_read_master dut (
    .aclk(aclk), .areset(areset), .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rlast(rlast),
    .Vld_O(Vld_O), .Rdy_I(Rdy_I), .Data_O(Data_O), .Last_O(Last_O));

  always #5 aclk = ~aclk;

  int n_chk = 0, n_err = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // transfer model: what the outputs must be, derived from counts of handshakes
  int          cyc = 0;
  bit          m_busy, m_fin;
  int          m_beats, m_bursts, m_ar_done, m_rl_done, m_beat_n, m_run_from, m_done_at;
  logic [63:0] m_base;
  // slave model
  int          sq[$];
  int          s_left, s_data, s_budget = -1;
  bit          rv_hold, rv_rand;
  int          ar_mode, rdy_mode;
  // observation logs
  logic [63:0] ar_log_addr[$];
  int          ar_log_len[$];
  int          last_idx, start_cyc, done_cyc, lastbeat_cyc;
  bit          ar_hs, r_hs, stall_prev, running, exp_arv;
  logic [63:0] prev_addr;
  logic [7:0]  prev_len;
  int          rem;

  initial forever begin
    @(negedge aclk);
    cyc++;
    ar_hs = 0; r_hs = 0;
    if (!areset) begin
      m_busy = 0; stall_prev = 0; sq.delete(); s_left = 0;
    end else begin
      running = m_busy && !m_fin && cyc >= m_run_from;
      exp_arv = running && m_ar_done < m_bursts && (m_ar_done - m_rl_done) < 4;
      chk("arvalid", arvalid, exp_arv);
      chk("rready", rready, Rdy_I && running);
      chk("vld_o", Vld_O, rvalid && running);
      chk("last_o", Last_O, Vld_O && running && m_beat_n == m_beats - 1);
      if (stall_prev) begin
        chk("araddr_hold", araddr, prev_addr);
        chk("arlen_hold", arlen, prev_len);
      end
      stall_prev = arvalid && !arready;
      prev_addr = araddr; prev_len = arlen;
      ar_hs = arvalid && arready;
      r_hs = rvalid && rready;
      if (ar_hs) begin
        rem = m_beats - m_ar_done * 256;
        chk("araddr", araddr, m_base + 64'(m_ar_done) * 64'h400);
        chk("arlen", arlen, (rem > 256 ? 256 : rem) - 1);
        ar_log_addr.push_back(araddr);
        ar_log_len.push_back(arlen);
        sq.push_back(arlen + 1);
        m_ar_done++;
      end
      if (r_hs) begin
        chk("data_o", Data_O, 32'hA000_0000 + m_beat_n);
        if (Last_O) last_idx = m_beat_n + 1;
        if (rlast) m_rl_done++;
        m_beat_n++;
        if (m_beat_n == m_beats) begin
          m_fin = 1; m_done_at = cyc + 2; lastbeat_cyc = cyc;
        end
      end
      chk("ctrl_done", ctrl_done, m_busy && cyc == m_done_at);
      if (ctrl_done) done_cyc = cyc;
      if (m_busy && cyc == m_done_at) m_busy = 0;
      if (ctrl_start && !m_busy) begin
        m_busy = 1; m_fin = 0; start_cyc = cyc;
        m_beats = int'((ctrl_xfer_size_in_bytes + 3) / 4);
        m_bursts = (m_beats + 255) / 256;
        m_base = ctrl_addr_offset & ~64'h3FF;
        m_ar_done = 0; m_rl_done = 0; m_beat_n = 0; s_data = 0;
        m_run_from = cyc + 2;
        if (m_beats == 0) begin m_fin = 1; m_done_at = cyc + 3; end
      end
    end
    @(posedge aclk); #1;
    if (r_hs) begin
      s_left--; s_data++;
      if (s_budget > 0) s_budget--;
    end
    if (s_left == 0 && sq.size() > 0) s_left = sq.pop_front();
    if (!areset) rvalid = 0;
    else if (!(rvalid && !r_hs))
      rvalid = s_left > 0 && !rv_hold && s_budget != 0 && (!rv_rand || $urandom_range(0, 1) == 1);
    rdata = 32'hA000_0000 + s_data;
    rlast = (s_left == 1);
    arready = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    Rdy_I = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic start(logic [63:0] a, logic [63:0] s);
    @(posedge aclk); #1;
    ctrl_addr_offset = a; ctrl_xfer_size_in_bytes = s; ctrl_start = 1;
    @(posedge aclk); #1;
    ctrl_start = 0;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    @(posedge aclk);
    @(posedge aclk);
    while (m_busy && n < 20000) begin @(posedge aclk); n++; end
    if (m_busy) begin
      n_err++; $display("FAIL %s: timeout waiting for ctrl_done", nm);
    end
    #1;
  endtask

  task automatic clr();
    ar_log_addr.delete(); ar_log_len.delete(); last_idx = -1;
  endtask

  initial begin
    areset = 0; ctrl_start = 0; ctrl_addr_offset = 0; ctrl_xfer_size_in_bytes = 0;
    arready = 1; rvalid = 0; rdata = 0; rlast = 0; Rdy_I = 1;
    ar_mode = 0; rdy_mode = 0; rv_hold = 0; rv_rand = 0;
    repeat (3) @(posedge aclk); #1;
    chk("rst_arvalid", arvalid, 0); chk("rst_done", ctrl_done, 0);
    chk("rst_araddr", araddr, 0); chk("rst_arlen", arlen, 0);
    chk("rst_rready", rready, 0); chk("rst_vld", Vld_O, 0); chk("rst_last", Last_O, 0);
    areset = 1;

    // 16 bytes at 0x1000
    clr(); start(64'h1000, 16); wait_idle("t16");
    chk("t16_nar", ar_log_addr.size(), 1);
    if (ar_log_addr.size() == 1) begin
      chk("t16_addr", ar_log_addr[0], 64'h1000); chk("t16_len", ar_log_len[0], 3);
    end
    chk("t16_last", last_idx, 4);
    chk("t16_done_lat", done_cyc - lastbeat_cyc, 2);

    // 2500 bytes at 0x1234 -> three bursts from 0x1000
    clr(); start(64'h1234, 2500); wait_idle("t2500");
    chk("t2500_nar", ar_log_addr.size(), 3);
    if (ar_log_addr.size() == 3) begin
      chk("t2500_a0", ar_log_addr[0], 64'h1000); chk("t2500_a1", ar_log_addr[1], 64'h1400);
      chk("t2500_a2", ar_log_addr[2], 64'h1800);
      chk("t2500_l0", ar_log_len[0], 255); chk("t2500_l1", ar_log_len[1], 255);
      chk("t2500_l2", ar_log_len[2], 112);
    end
    chk("t2500_last", last_idx, 625);

    clr(); start(64'h40, 6); wait_idle("t6");
    chk("t6_nar", ar_log_addr.size(), 1);
    if (ar_log_len.size() == 1) chk("t6_len", ar_log_len[0], 1);
    chk("t6_last", last_idx, 2);

    clr(); start(64'h40, 0); wait_idle("t0");
    chk("t0_nar", ar_log_addr.size(), 0);
    chk("t0_done_lat", done_cyc - start_cyc, 3);

    // outstanding limit with data withheld
    clr(); rv_hold = 1; start(64'h0, 8192);
    repeat (20) @(posedge aclk); #1;
    chk("os_nar4", ar_log_addr.size(), 4);
    chk("os_arvalid_low", arvalid, 0);
    s_budget = 256; rv_hold = 0;
    repeat (300) @(posedge aclk); #1;
    chk("os_nar5", ar_log_addr.size(), 5);
    chk("os_arvalid_low2", arvalid, 0);
    s_budget = -1; wait_idle("os");
    chk("os_nar8", ar_log_addr.size(), 8);
    chk("os_last", last_idx, 2048);

    // random backpressure, AR stalled first
    clr(); ar_mode = 2; rdy_mode = 1; rv_rand = 1; start(64'h2000, 3000);
    repeat (8) @(posedge aclk); #1;
    chk("stall_arvalid", arvalid, 1); chk("stall_araddr", araddr, 64'h2000);
    ar_mode = 1; wait_idle("rand");
    chk("rand_nar", ar_log_addr.size(), 3);
    if (ar_log_len.size() == 3) chk("rand_l2", ar_log_len[2], 237);
    chk("rand_last", last_idx, 750);
    ar_mode = 0; rdy_mode = 0; rv_rand = 0;

    // reset mid burst 2, then a clean transfer with an ignored restart
    clr(); start(64'h1234, 2500);
    for (int n = 0; n < 5000 && m_beat_n < 300; n++) @(posedge aclk);
    chk("rst_reached_b2", m_beat_n >= 300, 1);
    @(posedge aclk); #3; areset = 0; #1;
    chk("arst_arvalid", arvalid, 0); chk("arst_araddr", araddr, 0); chk("arst_arlen", arlen, 0);
    chk("arst_rready", rready, 0); chk("arst_vld", Vld_O, 0); chk("arst_last", Last_O, 0);
    chk("arst_done", ctrl_done, 0);
    repeat (3) @(posedge aclk); #1; areset = 1;
    clr(); start(64'h1234, 2500);
    repeat (20) @(posedge aclk);
    start(64'h8000, 16);
    wait_idle("post_rst");
    chk("pr_nar", ar_log_addr.size(), 3);
    if (ar_log_addr.size() == 3) begin
      chk("pr_a0", ar_log_addr[0], 64'h1000); chk("pr_a2", ar_log_addr[2], 64'h1800);
      chk("pr_l2", ar_log_len[2], 112);
    end
    chk("pr_last", last_idx, 625);

    repeat (5) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
